// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and helper functions for the multi-port
//                register file (bypass port selection, even parity).
//                Optional feature macro used by this slice: REGFILE_PARITY_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DWIDTH = 32;
    localparam int DEFAULT_AWIDTH = 5;
    localparam int DEPTH          = 1 << DEFAULT_AWIDTH;

    // Index of the highest set bit in a write-port match vector; the
    // highest-numbered write port owns a bypass when several ports hit.
    function automatic logic [1:0] f_bypass_sel(input logic [3:0] match);
        logic [1:0] sel;
        sel = 2'd0;
        for (int j = 0; j < 4; j++) begin
            if (match[j]) sel = 2'(j);
        end
        return sel;
    endfunction

    // Even parity bit over a zero-extended data word.
    function automatic logic f_even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy vector. Issue sets a bit, writeback clears
//                it; a set in the same cycle as a clear wins because a newer
//                producer is in flight. Also exposes next-state busy for each
//                read address so consumers see same-cycle writebacks as ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int AWIDTH   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       r_clk,
    input  logic                       r_rst,
    input  logic                       i_sb_set,
    input  logic [AWIDTH-1:0]          i_sb_addr,
    input  logic [NWR-1:0]             i_we_eff,
    input  logic [NWR*AWIDTH-1:0]      i_addr_rd,
    input  logic [NRD*AWIDTH-1:0]      i_addr_rs,
    output logic [(1<<AWIDTH)-1:0]     o_busy_vec,
    output logic [NRD-1:0]             o_busy_next_rs
);

    localparam int c_DEPTH = 1 << AWIDTH;

    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_busy_next;
    logic               w_sb_set_eff;

    assign w_sb_set_eff = i_sb_set && !((ZERO_REG != 0) && (i_sb_addr == '0));

    // Next busy state: clears from writeback first, then issue set overrides.
    always_comb begin
        w_busy_next = r_busy;
        for (int j = 0; j < NWR; j++) begin
            if (i_we_eff[j]) w_busy_next[i_addr_rd[j*AWIDTH +: AWIDTH]] = 1'b0;
        end
        if (w_sb_set_eff) w_busy_next[i_sb_addr] = 1'b1;
        if (ZERO_REG != 0) w_busy_next[0] = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) r_busy <= '0;
        else        r_busy <= w_busy_next;
    end

    // Next-state busy lookup per read port.
    always_comb begin
        o_busy_next_rs = '0;
        for (int k = 0; k < NRD; k++) begin
            o_busy_next_rs[k] = w_busy_next[i_addr_rs[k*AWIDTH +: AWIDTH]];
        end
    end

    assign o_busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port register file with registered,
//                fully bypassed reads and an issue-stage busy scoreboard.
//                Optional: REGFILE_PARITY_EN adds a stored even-parity bit per
//                entry, r_inj_par (error injection) and r_par_err outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DWIDTH   = DEFAULT_DWIDTH,
    parameter int AWIDTH   = DEFAULT_AWIDTH,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       r_clk,
    input  logic                       r_rst,
    input  logic                       r_read_reg,
    input  logic [NRD*AWIDTH-1:0]      r_addr_rs,
    output logic [NRD*DWIDTH-1:0]      r_data_out_rs,
    output logic [NRD-1:0]             r_busy_out_rs,
    input  logic [NWR-1:0]             r_we,
    input  logic [NWR*AWIDTH-1:0]      r_addr_rd,
    input  logic [NWR*DWIDTH-1:0]      r_data_rd,
    input  logic                       r_sb_set,
    input  logic [AWIDTH-1:0]          r_sb_addr,
`ifdef REGFILE_PARITY_EN
    input  logic [NWR-1:0]             r_inj_par,
    output logic [NRD-1:0]             r_par_err,
`endif
    output logic [(1<<AWIDTH)-1:0]     r_busy_vec
);

    localparam int c_DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] r_mem [c_DEPTH];
    logic [NWR-1:0]    w_we_eff;
    logic [NRD-1:0]    w_busy_next_rs;

    // A write to register 0 is dropped when it is hardwired to zero.
    always_comb begin
        w_we_eff = '0;
        for (int j = 0; j < NWR; j++) begin
            w_we_eff[j] = r_we[j] &&
                          !((ZERO_REG != 0) && (r_addr_rd[j*AWIDTH +: AWIDTH] == '0));
        end
    end

    // Storage update; later ports overwrite earlier ones on a collision.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (w_we_eff[j]) r_mem[r_addr_rd[j*AWIDTH +: AWIDTH]] <= r_data_rd[j*DWIDTH +: DWIDTH];
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    logic          r_par [c_DEPTH];
    logic [NWR-1:0] w_par_wr;

    // Parity of each incoming word, optionally inverted for error injection.
    always_comb begin
        logic [63:0] v_ext;
        w_par_wr = '0;
        for (int j = 0; j < NWR; j++) begin
            v_ext = '0;
            v_ext[DWIDTH-1:0] = r_data_rd[j*DWIDTH +: DWIDTH];
            w_par_wr[j] = f_even_parity(v_ext) ^ r_inj_par[j];
        end
    end

    // Parity storage, updated alongside the data words.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            for (int i = 0; i < c_DEPTH; i++) r_par[i] <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (w_we_eff[j]) r_par[r_addr_rd[j*AWIDTH +: AWIDTH]] <= w_par_wr[j];
            end
        end
    end
`endif

    regfile_scoreboard #(
        .AWIDTH   (AWIDTH),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .r_clk          (r_clk),
        .r_rst          (r_rst),
        .i_sb_set       (r_sb_set),
        .i_sb_addr      (r_sb_addr),
        .i_we_eff       (w_we_eff),
        .i_addr_rd      (r_addr_rd),
        .i_addr_rs      (r_addr_rs),
        .o_busy_vec     (r_busy_vec),
        .o_busy_next_rs (w_busy_next_rs)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AWIDTH-1:0] w_ra;
        logic [3:0]        w_match;
        logic [DWIDTH-1:0] w_rdata;
        logic              w_rzero;
        logic [DWIDTH-1:0] r_dout;
        logic              r_bout;

        assign w_ra    = r_addr_rs[k*AWIDTH +: AWIDTH];
        assign w_rzero = (ZERO_REG != 0) && (w_ra == '0);

        // Read data: stored word, replaced by a same-cycle write when one hits.
        always_comb begin
            logic [1:0] v_sel;
            w_match = '0;
            for (int j = 0; j < NWR; j++) begin
                w_match[j] = w_we_eff[j] && (r_addr_rd[j*AWIDTH +: AWIDTH] == w_ra);
            end
            v_sel   = f_bypass_sel(w_match);
            w_rdata = r_mem[w_ra];
            if (|w_match) begin
                for (int j = 0; j < NWR; j++) begin
                    if (2'(j) == v_sel) w_rdata = r_data_rd[j*DWIDTH +: DWIDTH];
                end
            end
            if (w_rzero) w_rdata = '0;
        end

        // Output registers, held while read enable is low.
        always_ff @(posedge r_clk or negedge r_rst) begin
            if (!r_rst) begin
                r_dout <= '0;
                r_bout <= 1'b0;
            end else if (r_read_reg) begin
                r_dout <= w_rdata;
                r_bout <= w_busy_next_rs[k];
            end
        end

        assign r_data_out_rs[k*DWIDTH +: DWIDTH] = r_dout;
        assign r_busy_out_rs[k]                  = r_bout;

`ifdef REGFILE_PARITY_EN
        logic w_perr;
        logic r_perr;

        // Stored-word parity check; bypassed and zero-register reads are clean.
        always_comb begin
            logic [63:0] v_ext;
            v_ext = '0;
            v_ext[DWIDTH-1:0] = r_mem[w_ra];
            w_perr = 1'b0;
            if (!(|w_match) && !w_rzero) w_perr = f_even_parity(v_ext) ^ r_par[w_ra];
        end

        // Parity error flag registered together with the read data.
        always_ff @(posedge r_clk or negedge r_rst) begin
            if (!r_rst)          r_perr <= 1'b0;
            else if (r_read_reg) r_perr <= w_perr;
        end

        assign r_par_err[k] = r_perr;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed self-checking bench for regfile_mp (NRD=2, NWR=2).
//                Expected read results are queued when a read is driven and
//                compared after the capturing clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              read_reg;
    logic [NR*AW-1:0]  addr_rs;
    logic [NR*DW-1:0]  data_out;
    logic [NR-1:0]     busy_out;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  addr_rd;
    logic [NW*DW-1:0]  data_rd;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic [(1<<AW)-1:0] busy_vec;
`ifdef REGFILE_PARITY_EN
    logic [NW-1:0]     inj_par;
    logic [NR-1:0]     par_err;
`endif

    typedef struct {
        string       tag;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DWIDTH(DW), .AWIDTH(AW), .NRD(NR), .NWR(NW), .ZERO_REG(1)
    ) dut (
        .r_clk         (clk),
        .r_rst         (rst),
        .r_read_reg    (read_reg),
        .r_addr_rs     (addr_rs),
        .r_data_out_rs (data_out),
        .r_busy_out_rs (busy_out),
        .r_we          (we),
        .r_addr_rd     (addr_rd),
        .r_data_rd     (data_rd),
        .r_sb_set      (sb_set),
        .r_sb_addr     (sb_addr),
`ifdef REGFILE_PARITY_EN
        .r_inj_par     (inj_par),
        .r_par_err     (par_err),
`endif
        .r_busy_vec    (busy_vec)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] b);
        exp_t e;
        e.tag = tag; e.d0 = d0; e.d1 = d1; e.b = b;
        sbq.push_back(e);
    endtask

    // One clock edge, then drain every queued expectation against the outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.tag, ".d0"}, 64'(data_out[31:0]),  64'(e.d0));
            chk({e.tag, ".d1"}, 64'(data_out[63:32]), 64'(e.d1));
            chk({e.tag, ".busy"}, 64'(busy_out), 64'(e.b));
        end
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
        we = en; addr_rd = {a1, a0}; data_rd = {d1, d0};
    endtask

    initial begin
        rst = 1'b0; read_reg = 1'b0; addr_rs = '0; sb_set = 1'b0; sb_addr = '0;
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
`ifdef REGFILE_PARITY_EN
        inj_par = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset.dout", 64'(data_out), 64'h0);
        chk("reset.busy", 64'(busy_out), 64'h0);
        chk("reset.vec",  64'(busy_vec), 64'h0);
        rst = 1'b1;

        // Write x3, then read it on both ports.
        wr(2'b01, 5'd3, 32'h12345678, 5'd0, 32'h0);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        read_reg = 1'b1; addr_rs = {5'd3, 5'd3};
        push("rd_x3", 32'h12345678, 32'h12345678, 2'b00);
        tick();

        // Both ports write x7 while reading x7: port 1 wins, bypassed.
        wr(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF);
        addr_rs = {5'd7, 5'd7};
        push("collide_byp", 32'h5555FFFF, 32'h5555FFFF, 2'b00);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        push("collide_stored", 32'h5555FFFF, 32'h5555FFFF, 2'b00);
        tick();

        // Register 0 ignores writes and scoreboard sets.
        wr(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
        sb_set = 1'b1; sb_addr = 5'd0; addr_rs = {5'd0, 5'd0};
        push("x0_same", 32'h0, 32'h0, 2'b00);
        tick();
        chk("x0_vec", 64'(busy_vec[0]), 64'h0);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        sb_set = 1'b0;
        push("x0_after", 32'h0, 32'h0, 2'b00);
        tick();

        // Scoreboard: set busy[9] and read it.
        sb_set = 1'b1; sb_addr = 5'd9; addr_rs = {5'd3, 5'd9};
        push("sb_set9", 32'h0, 32'h12345678, 2'b01);
        tick();
        chk("sb_vec9_set", 64'(busy_vec[9]), 64'h1);
        // Writeback to x9 while reading: data bypassed, seen as ready.
        sb_set = 1'b0;
        wr(2'b01, 5'd9, 32'h42, 5'd0, 32'h0);
        push("sb_wb9", 32'h42, 32'h12345678, 2'b00);
        tick();
        chk("sb_vec9_clr", 64'(busy_vec[9]), 64'h0);
        // Same-cycle set and writeback: set wins.
        sb_set = 1'b1; sb_addr = 5'd9;
        wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h43);
        push("sb_setclr9", 32'h43, 32'h12345678, 2'b01);
        tick();
        chk("sb_vec9_both", 64'(busy_vec[9]), 64'h1);

        // Hold: read enable low keeps outputs while a write to x4 lands.
        sb_set = 1'b0; read_reg = 1'b0;
        wr(2'b01, 5'd4, 32'h99, 5'd0, 32'h0);
        addr_rs = {5'd3, 5'd4};
        push("hold", 32'h43, 32'h12345678, 2'b01);
        tick();
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        push("hold2", 32'h43, 32'h12345678, 2'b01);
        tick();
        read_reg = 1'b1;
        push("hold_release", 32'h99, 32'h12345678, 2'b00);
        tick();

        // Write x5 and mark it busy, then reset asynchronously mid-cycle.
        wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        sb_set = 1'b1; sb_addr = 5'd5; addr_rs = {5'd3, 5'd5};
        push("pre_rst_x5", 32'hDEADBEEF, 32'h12345678, 2'b01);
        tick();
        chk("pre_rst_vec5", 64'(busy_vec[5]), 64'h1);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        sb_set = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst.dout", 64'(data_out), 64'h0);
        chk("async_rst.busy", 64'(busy_out), 64'h0);
        chk("async_rst.vec",  64'(busy_vec), 64'h0);
        tick();
        #2 rst = 1'b1;
        addr_rs = {5'd9, 5'd5};
        push("post_rst", 32'h0, 32'h0, 2'b00);
        tick();
        chk("post_rst.vec", 64'(busy_vec), 64'h0);

`ifdef REGFILE_PARITY_EN
        // Injected parity error on a stored word is flagged on read.
        wr(2'b01, 5'd11, 32'h1234, 5'd0, 32'h0);
        inj_par = 2'b01; addr_rs = {5'd3, 5'd11};
        push("par_byp", 32'h1234, 32'h0, 2'b00);
        tick();
        chk("par_byp_err", 64'(par_err), 64'h0);
        wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        inj_par = 2'b00;
        push("par_rd", 32'h1234, 32'h0, 2'b00);
        tick();
        chk("par_err", 64'(par_err), 64'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read core register file.
- Configurable read-port count, write-port count, width and depth.
- Registered reads with full write-to-read bypass, gated by read enable.
- Per-register busy scoreboard for issue-stage hazard detection. Sits between decode/issue and writeback.

Parameters:
- DWIDTH, 32, data width per register
- AWIDTH, 5, address width; depth = 1<<AWIDTH
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
- r_clk  in  1  clock
- r_rst  in  1  reset, asynchronous, active-low
- r_read_reg  in  1  read enable; 0 holds all read outputs
- r_addr_rs  in  NRD*AWIDTH  read addresses, port k at [k*AWIDTH +: AWIDTH]
- r_data_out_rs  out  NRD*DWIDTH  registered read data
- r_busy_out_rs  out  NRD  registered busy flag of the read register
- r_we  in  NWR  write enables
- r_addr_rd  in  NWR*AWIDTH  write addresses
- r_data_rd  in  NWR*DWIDTH  write data
- r_sb_set  in  1  mark r_sb_addr busy (instruction issued)
- r_sb_addr  in  AWIDTH  scoreboard set address
- r_busy_vec  out  1<<AWIDTH  live busy bits (registered state)

Behaviour:
- Reset (r_rst low, asynchronous): all entries 0, all busy bits 0, r_data_out_rs 0, r_busy_out_rs 0.
- Effective write, port j: r_we[j] && !(ZERO_REG && addr==0). Commits on posedge r_clk.
- Write collision (NWR=2, same address, both effective): port 1 wins.
- Read latency 1 cycle. When r_read_reg=1, each port samples at posedge. When r_read_reg=0, outputs hold previous values; writes and scoreboard still update.
- Bypass: if an effective write targets r_addr_rs[k] in the same cycle, the output takes that write data instead of stored data. Highest-index matching write port wins.
- ZERO_REG=1 and read address 0: data 0 and busy 0, regardless of writes.
- Scoreboard set: on r_sb_set with an allowed address, busy[addr] <= 1.
- Scoreboard clear: every effective write clears busy[addr_rd].
- Set and clear on the same register in the same cycle: set wins, because a new producer is in flight.
- r_sb_set to register 0 with ZERO_REG=1 is ignored.
- r_busy_out_rs[k] reports next-state busy for the read address (bypassed like data), so a consumer sees a same-cycle writeback as ready.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion behaves as from clean reset.
- No combinational path from inputs to any output.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit, computed on write.
  - Extra input r_inj_par (NWR bits) inverts the stored parity of the written word, for test.
  - Extra output r_par_err (NRD bits), registered with read data: 1 when stored data/parity mismatch.
  - Bypassed reads always report 0. Reset value 0.
- Not defined: no parity storage, no r_inj_par/r_par_err ports; behaviour otherwise identical.

Decomposition:
- Shared package regfile_pkg:
  - default DWIDTH/AWIDTH
  - function for the highest-priority bypass select
  - parity function
  - localparam DEPTH
- One natural sub-module, regfile_scoreboard: busy vector, set/clear priority, next-state busy lookup. Instantiated once.
- Storage and read muxing stay in regfile_mp.

Test Plan:
- Reset: assert r_rst low mid-run after writing x5=0xDEADBEEF and setting busy[5] -> all read outputs 0, r_busy_vec all 0, read x5 after release returns 0.
- Write/read: write x3=0x12345678, next cycle read rs0=3, rs1=3 with r_read_reg=1 -> both outputs 0x12345678 one cycle later.
- Bypass and collision (NWR=2): same cycle ports 0/1 write x7 with 0xAAAA0000/0x5555FFFF while reading x7 -> output 0x5555FFFF, stored value 0x5555FFFF.
- Zero register: write x0=0xFFFFFFFF, r_sb_set addr 0 -> read x0 gives 0, busy 0, r_busy_vec[0]=0.
- Scoreboard:
  - Set busy[9], read x9 -> busy_out 1.
  - Write x9=0x42 while reading -> data 0x42, busy_out 0.
  - Same cycle set and write x9 -> busy[9] stays 1.
- Hold: r_read_reg=0 while writing x4=0x99 and reading x4 -> outputs unchanged. Raise r_read_reg -> 0x99. With REGFILE_PARITY_EN: inject on write x4, read -> r_par_err=1.
